// File: rtl/mac_result_collector_pkg.sv
// Shared types and helpers for the MAC result collector: accumulator width,
// FIFO entry tag and the signed-add overflow test.
package mac_result_collector_pkg;

  function automatic int calc_aw(input int bits, input int guard);
    return 2 * bits + guard;
  endfunction

  // A FIFO entry is {data, tag}; data width depends on parameters, so only the tag is fixed here
  typedef struct packed {
    logic is_acc;
    logic ovf;
  } entry_tag_t;

  localparam int TAG_W = $bits(entry_tag_t);

  function automatic logic add_ovf(input logic a_sign, input logic b_sign, input logic sum_sign);
    return (a_sign == b_sign) && (sum_sign != a_sign);
  endfunction

endpackage

// File: rtl/mac_result_collector_if.sv
// Issue/result/output bundle of the MAC result collector.
interface mac_result_collector_if
  import mac_result_collector_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int GUARD = 8,
  parameter int DEPTH = 4
);
  localparam int AW = calc_aw(BITS, GUARD);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              issue_valid;
  logic              issue_ready;
  logic              issue_acc;
  logic              issue_last;
  logic [2*BITS-1:0] dp_result;
  logic              out_valid;
  logic              out_ready;
  logic [AW-1:0]     out_data;
  logic              out_is_acc;
  logic              out_ovf;
  logic [CW-1:0]     count;

  modport slave (
    input  issue_valid, issue_acc, issue_last, dp_result, out_ready,
    output issue_ready, out_valid, out_data, out_is_acc, out_ovf, count
  );

  modport master (
    output issue_valid, issue_acc, issue_last, dp_result, out_ready,
    input  issue_ready, out_valid, out_data, out_is_acc, out_ovf, count
  );
endinterface

// File: rtl/mac_result_collector_chk.sv
// Structural invariants of the collector's output FIFO.
module mac_result_collector_chk #(
  parameter int DEPTH = 4
) (
  input logic                   clk,
  input logic                   rst,
  input logic                   push,
  input logic                   full,
  input logic [$clog2(DEPTH):0] count
);
  // Credit scheme guarantees a full FIFO is never pushed
  a_no_push_on_full: assert property (@(posedge clk) disable iff (rst) !(push && full));

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
                                  count <= ($clog2(DEPTH)+1)'(DEPTH));
endmodule

// File: rtl/mac_result_fifo.sv
// Synchronous FIFO with occupancy count; head outputs come straight from flops,
// so a pushed word becomes visible the cycle after the push.
module mac_result_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [W-1:0]           push_data,
  input  logic                   pop_ready,
  output logic                   head_valid,
  output logic [W-1:0]           head_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          valid_q, valid_d;
  logic [W-1:0]  head_q, head_d;
  logic          pop_s;

  // Next storage/pointer state; head is looked up after this cycle's write
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_s    = valid_q & pop_ready;
    if (push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + (PW+1)'(push) - (PW+1)'(pop_s);
    valid_d = (count_d != '0);
    head_d  = mem_d[rd_ptr_d];
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
    end
  end

  assign head_valid = valid_q;
  assign head_data  = head_q;
  assign count      = count_q;
  assign full       = (count_q == (PW+1)'(DEPTH));

endmodule

// File: rtl/mac_result_collector.sv
// Tracks issue validity beside the MAC datapath, captures its result one cycle
// later, optionally accumulates, and queues outputs in a small FIFO.
module mac_result_collector
  import mac_result_collector_pkg::*;
#(
  parameter int BITS  = 32,
  parameter int GUARD = 8,
  parameter int DEPTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  mac_result_collector_if.slave  bus
);
  localparam int AW = calc_aw(BITS, GUARD);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = AW + TAG_W;

  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_acc_q, s1_acc_d;
  logic                 s1_last_q, s1_last_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  logic                 fire_s;
  logic                 push_s;
  logic [AW-1:0]        push_data_s;
  entry_tag_t           push_tag_s;
  logic signed [AW-1:0] sx_s;
  logic signed [AW-1:0] sum_s;
  logic                 this_ovf_s;
  logic [EW-1:0]        head_s;
  logic                 head_valid_s;
  logic [CW-1:0]        count_s;
  logic                 full_s;
  entry_tag_t           head_tag_s;

  // The in-flight op holds a credit, so an issued result always has a FIFO slot
  assign bus.issue_ready = ((count_s + CW'(s1_valid_q)) < CW'(DEPTH));
  assign fire_s          = bus.issue_valid & bus.issue_ready;

  // Stage-1 tracking, accumulation and push selection
  always_comb begin
    s1_valid_d  = fire_s;
    s1_acc_d    = fire_s & bus.issue_acc;
    s1_last_d   = fire_s & bus.issue_last;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    push_s      = 1'b0;
    sx_s        = AW'($signed(bus.dp_result));
    sum_s       = acc_q + sx_s;
    this_ovf_s  = add_ovf(acc_q[AW-1], sx_s[AW-1], sum_s[AW-1]);
    push_data_s = sx_s;
    push_tag_s  = '0;
    if (s1_valid_q) begin
      case ({s1_acc_q, s1_last_q})
        2'b00, 2'b01: begin
          push_s = 1'b1;
        end
        2'b10: begin
          acc_d = sum_s;
          ovf_d = ovf_q | this_ovf_s;
        end
        2'b11: begin
          push_s            = 1'b1;
          push_data_s       = sum_s;
          push_tag_s.is_acc = 1'b1;
          push_tag_s.ovf    = ovf_q | this_ovf_s;
          acc_d             = '0;
          ovf_d             = 1'b0;
        end
        default: begin
          push_s = 1'b0;
        end
      endcase
    end else begin
      push_s = 1'b0;
    end
  end

  // Stage-1 and accumulator registers
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_acc_q   <= 1'b0;
      s1_last_q  <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_acc_q   <= s1_acc_d;
      s1_last_q  <= s1_last_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
    end
  end

  mac_result_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_s),
    .push_data  ({push_data_s, push_tag_s}),
    .pop_ready  (bus.out_ready),
    .head_valid (head_valid_s),
    .head_data  (head_s),
    .count      (count_s),
    .full       (full_s)
  );

  mac_result_collector_chk #(
    .DEPTH (DEPTH)
  ) u_chk (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .full  (full_s),
    .count (count_s)
  );

  assign head_tag_s     = head_s[TAG_W-1:0];
  assign bus.out_valid  = head_valid_s;
  assign bus.out_data   = head_s[EW-1:TAG_W];
  assign bus.out_is_acc = head_tag_s.is_acc;
  assign bus.out_ovf    = head_tag_s.ovf;
  assign bus.count      = count_s;

endmodule
